// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: groups the FIFO read port, the flush strobe and the
// valid/ready output stream of fifo_stream_reader. The master modport is the
// reader itself; the slave modport is the FIFO plus the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flush,
    input  m_ready,
    output fifo_r_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flush,
    output m_ready,
    input  fifo_r_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (r_en / registered data_out)
// into a valid/ready stream. A 3-entry prefetch buffer covers the FIFO's
// one-cycle read latency so one word per cycle flows under continuous ready.
// Optional feature: define FIFO_STREAM_READER_STATS_EN to add the 16-bit
// delivered-word counter port o_words_out.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [15:0]          o_words_out
`endif
);

  localparam int DEPTH = 3;

  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [1:0]            r_wr_idx;
  logic [1:0]            r_rd_idx;
  logic [1:0]            r_occ;
  logic                  r_inflight;

  logic                  w_issue;
  logic                  w_pop;
  logic [2:0]            w_level;

  // Circular index step over the three buffer slots (2 wraps to 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Buffered words plus the word already requested must leave room for one more.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_issue = rst && !bus.flush && !bus.fifo_empty && (w_level < 3'd3);
  assign w_pop   = bus.m_valid && bus.m_ready;

  assign bus.fifo_r_en = w_issue;
  assign bus.m_valid   = (r_occ != 2'd0) && !bus.flush;
  assign bus.m_data    = r_buf[r_rd_idx];

  // Prefetch buffer: capture the word requested last cycle, pop on handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_idx   <= 2'd0;
      r_rd_idx   <= 2'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else if (bus.flush) begin
      r_wr_idx   <= 2'd0;
      r_rd_idx   <= 2'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_buf[r_wr_idx] <= bus.fifo_data;
        r_wr_idx        <= next_idx(r_wr_idx);
      end
      if (w_pop) begin
        r_rd_idx <= next_idx(r_rd_idx);
      end
      case ({r_inflight, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] r_words_out;

  // Delivered-word counter; survives flush, cleared only by reset, wraps freely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_words_out <= 16'd0;
    end else if (w_pop) begin
      r_words_out <= r_words_out + 16'd1;
    end
  end

  assign o_words_out = r_words_out;
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's synchronous FIFO: it drains words through the FIFO's `r_en`/registered `data_out` port and re-presents them as a valid/ready stream. A 3-entry prefetch buffer hides the FIFO's one-cycle read latency, so the stream sustains one word per cycle under continuous `m_ready`. It sits between a synchronous FIFO's read port and any downstream consumer (serializer, packetizer, bus master).

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached FIFO.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_en`  out  1  FIFO read enable.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `words_out`  out  16  delivered-word count. Present only with `FIFO_STREAM_READER_STATS_EN`.

## Operation
- Internal state:
  - 3-entry circular buffer with 2-bit write and read indices (wrap 2→0).
  - `occ` (0..3): buffered-word count.
  - `inflight` (1 bit): a read was issued last cycle.
- Issue rule (combinational; no path from `m_ready`): `fifo_r_en = rst && !flush && !fifo_empty && (occ + inflight) < 3`.
  - `fifo_r_en` is never asserted while `fifo_empty` is high.
  - Every asserted `fifo_r_en` is therefore an accepted read.
- Capture: `inflight` is set next cycle iff `fifo_r_en` is asserted. While `inflight`=1, `fifo_data` is written at the write index, and the write index and `occ` advance.
- Output:
  - `m_valid = (occ != 0) && !flush`.
  - `m_data` = buffer entry at the read index.
  - A pop occurs when `m_valid && m_ready`: the read index advances and `occ` decrements.
- Capture and pop in the same cycle: `occ` is unchanged and both indices advance.
- Word order: strictly FIFO order; no word is duplicated or dropped except by `flush` or reset.
- `m_data` holds its value while `m_valid && !m_ready`.
- `flush` high at an edge:
  - Next-cycle `occ`=0, indices=0, `inflight`=0.
  - Data arriving on `fifo_data` the cycle after flush is discarded.
  - No pop is counted during the flush cycle.
- Reset (`rst`=0 at an edge, including mid-stream):
  - Effects identical to `flush`.
  - `fifo_r_en` is 0 during every cycle `rst` is low.

## Timing
- Reset values: `fifo_r_en`=0, `m_valid`=0, `m_data`=0 (buffer cleared), `words_out`=0.
- Latency: `fifo_empty` falls in cycle 0 → `fifo_r_en`=1 in cycle 0 → word on `fifo_data` in cycle 1 → `m_valid`=1 with that word in cycle 2.
- Throughput: with `m_ready` held high and the FIFO non-empty, one pop per cycle from cycle 2 onward, with no bubbles.
- Backpressure: with `m_ready` low, at most 3 reads are issued, then `fifo_r_en` stays 0 until a pop. The cycle after a pop, `fifo_r_en` may assert again.
- Boundary: when the FIFO goes empty, `m_valid` deasserts exactly when `occ` reaches 0. No read is issued while empty.

## Configuration
- `FIFO_STREAM_READER_STATS_EN` defined:
  - Port `words_out[15:0]` exists.
  - It increments by 1 on each pop and wraps 0xFFFF→0x0000.
  - It is cleared by reset only; `flush` does not clear it.
- Not defined: the port and counter are absent, and the remaining behaviour is identical.

## Test plan
- Basic: reset, FIFO preloaded 0x11, 0x22, 0x33, `m_ready`=1 → `m_data` 0x11, 0x22, 0x33 in cycles 2, 3, 4; then `m_valid`=0 and `fifo_r_en`=0.
- Full rate: 16 words 0x00..0x0F, `m_ready`=1 → 16 consecutive pops in cycles 2..17 with no bubble; with stats enabled, `words_out`=16.
- Backpressure: 8 words, `m_ready`=0 for 10 cycles → exactly 3 `fifo_r_en` pulses, `m_data`=0x00 held; release → 0x00..0x07 in order with none lost.
- Empty toggling: `fifo_empty` alternates every cycle while `m_ready`=1 → `fifo_r_en` is never high while `fifo_empty`=1, and output order is preserved.
- Flush with in-flight read: `occ`=2, `inflight`=1, pulse `flush` → next cycle `m_valid`=0; the arriving word is discarded; the next FIFO word is the first one delivered.
- Reset mid-stream: `rst`=0 for 1 cycle during a burst → all outputs return to reset values the next cycle (`words_out`=0), `fifo_r_en`=0 during reset, and streaming resumes with a latency of 2.
